interval_timer: RTL

- Parameterised successor to the single-shot seconds counter.
- Counts a programmable number of ticks. Each tick is PRESCALE clock cycles, so a fast clock gives real-time "seconds".
- Emits a one-cycle `signal` pulse on expiry.
- Adds what the single-shot counter lacks: one-shot/periodic mode, pause/resume, abort, live remaining-count readback and an expiry counter. Sits between the FSM controllers and any timed event.

---
 rtl/interval_timer.sv | 103 ++++++++++
 1 files changed

// File: rtl/interval_timer.sv
// Programmable interval timer: counts N ticks of PRESCALE cycles, one-shot or periodic.
// Latency: signal pulses in the cycle after edge E0 + N*PRESCALE (E0 = accepting edge); pauses add 1:1.
// Backpressure: none; pause freezes the count, stop aborts, start (N != 0) restarts from any state.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   counterSeconds   tick count N, latched on an accepted start
//   start/stop       restart / abort requests, sampled every edge (stop wins)
//   pause            level; freezes prescaler and remaining while high
//   periodic         mode latched on accepted start (1 = auto-reload)
//   signal           one-cycle expiry pulse
//   busy             high while RUN or HOLD
//   remaining        ticks left (0 when idle)
//   expireCount      expiries since reset, wraps
module interval_timer #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 50000000,
    parameter int EXPW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] counterSeconds,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    output logic             signal,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic [EXPW-1:0]  expireCount
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] n_lat;
    logic             per_lat;
    logic             start_ok;

    // A start with N = 0 is ignored entirely.
    assign start_ok = start && (counterSeconds != '0);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            n_lat       <= '0;
            per_lat     <= 1'b0;
            signal      <= 1'b0;
            remaining   <= '0;
            expireCount <= '0;
        end else begin
            signal <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                remaining <= '0;
                presc     <= '0;
            end else if (start_ok) begin
                // Fresh start discards any expiry that would have happened on this edge.
                n_lat     <= counterSeconds;
                per_lat   <= periodic;
                remaining <= counterSeconds;
                presc     <= '0;
                state     <= pause ? HOLD : RUN;
            end else if (state != IDLE) begin
                if (pause) begin
                    state <= HOLD;
                end else begin
                    // The edge that sees pause low already counts, so a pause
                    // of k cycles delays expiry by exactly k cycles.
                    state <= RUN;
                    if (presc == PMAX) begin
                        presc <= '0;
                        if (remaining > WIDTH'(1)) begin
                            remaining <= remaining - 1'b1;
                        end else begin
                            signal      <= 1'b1;
                            expireCount <= expireCount + 1'b1;
                            if (per_lat) begin
                                remaining <= n_lat;
                            end else begin
                                state     <= IDLE;
                                remaining <= '0;
                            end
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end
        end
    end

endmodule
